// File: rtl/gray_pkg.sv
// Shared types and Gray/binary conversion helpers for the Gray count sequencer.
// Conversion functions work on a 32-bit container; callers truncate to their width.
package gray_pkg;

    typedef logic [1:0] state_t;

    localparam state_t IDLE = 2'd0;
    localparam state_t RUN  = 2'd1;
    localparam state_t DONE = 2'd2;

    localparam int unsigned CONV_W = 32;

    function automatic logic [CONV_W-1:0] bin2gray(input logic [CONV_W-1:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [CONV_W-1:0] gray2bin(input logic [CONV_W-1:0] g);
        logic [CONV_W-1:0] b;
        b = '0;
        for (int i = 0; i < CONV_W; i++) begin
            b[i] = ^(g >> i);
        end
        return b;
    endfunction

endpackage

// File: rtl/gray_to_bin.sv
// WIDTH-bit Gray-to-binary converter: each binary bit is the XOR of all Gray bits
// at or above its position.
module gray_to_bin #(
    parameter int unsigned WIDTH = 4
) (
    input  logic [WIDTH-1:0] gray,
    output logic [WIDTH-1:0] bin
);

    always_comb begin
        bin = '0;
        for (int i = 0; i < WIDTH; i++) begin
            bin[i] = ^(gray >> i);
        end
    end

endmodule

// File: rtl/gray_count_seq.sv
// Gray-code up/down count sequencer with start/stop/load control, presenting each
// code word and its binary value over a valid/ready handshake.
module gray_count_seq
    import gray_pkg::*;
#(
    parameter int unsigned WIDTH     = 4,
    parameter int unsigned MAX_COUNT = 2**WIDTH - 1,
    parameter bit          WRAP      = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             stop,
    input  logic             dir,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] gray_o,
    output logic [WIDTH-1:0] bin_o,
    output logic             busy,
    output logic             done
);

    localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX_COUNT);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] gray_q, gray_d;
    logic [WIDTH-1:0] bin;
    logic [WIDTH-1:0] next_bin;
    logic [WIDTH-1:0] load_clamped;
    logic             accept;
    logic             at_term;

    gray_to_bin #(
        .WIDTH (WIDTH)
    ) u_gray_to_bin (
        .gray (gray_q),
        .bin  (bin)
    );

    assign accept       = (state_q == RUN) && out_ready;
    assign at_term      = dir ? (bin == MAX_V) : (bin == '0);
    assign load_clamped = (load_val > MAX_V) ? MAX_V : load_val;

    // Terminal steps only matter when wrapping; otherwise the count is held.
    always_comb begin
        if (at_term) begin
            next_bin = dir ? '0 : MAX_V;
        end else begin
            next_bin = dir ? bin + 1'b1 : bin - 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        gray_d  = gray_q;
        case (state_q)
            IDLE: begin
                if (load) begin
                    gray_d = WIDTH'(bin2gray(CONV_W'(load_clamped)));
                end
                if (start) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (accept && !(at_term && !WRAP)) begin
                    gray_d = WIDTH'(bin2gray(CONV_W'(next_bin)));
                end
                // An abort wins over entering DONE on the same cycle.
                if (stop) begin
                    state_d = IDLE;
                end else if (accept && at_term && !WRAP) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            gray_q  <= '0;
        end else begin
            state_q <= state_d;
            gray_q  <= gray_d;
        end
    end

    assign gray_o    = gray_q;
    assign bin_o     = bin;
    assign out_valid = (state_q == RUN);
    assign busy      = (state_q == RUN);
    assign done      = (state_q == DONE);

endmodule

// File: tb/tb_gray_count_seq.sv
// Bench for gray_count_seq: two instances (stop-at-terminal, and wrap at 9) share
// stimulus and are each checked every cycle against a counting model.
module tb_gray_count_seq;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0, stop = 1'b0, dir = 1'b0, load = 1'b0, out_ready = 1'b0;
    logic [W-1:0] load_val = '0;

    logic         valid_w [2];
    logic         busy_w  [2];
    logic         done_w  [2];
    logic [W-1:0] gray_w  [2];
    logic [W-1:0] bin_w   [2];

    gray_count_seq #(.WIDTH(W), .MAX_COUNT(15), .WRAP(1'b0)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .dir(dir), .load(load),
        .load_val(load_val), .out_ready(out_ready), .out_valid(valid_w[0]),
        .gray_o(gray_w[0]), .bin_o(bin_w[0]), .busy(busy_w[0]), .done(done_w[0])
    );

    gray_count_seq #(.WIDTH(W), .MAX_COUNT(9), .WRAP(1'b1)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .dir(dir), .load(load),
        .load_val(load_val), .out_ready(out_ready), .out_valid(valid_w[1]),
        .gray_o(gray_w[1]), .bin_o(bin_w[1]), .busy(busy_w[1]), .done(done_w[1])
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Model: mode 0 = idle, 1 = running, 2 = done pulse; cnt is the binary count.
    int max_c  [2] = '{15, 9};
    bit wrap_c [2] = '{1'b0, 1'b1};
    int m_mode [2];
    int m_cnt  [2];
    bit adv    [2];
    bit full_wrap [2];
    logic [W-1:0] prev_gray [2];

    task automatic check_eq(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_mode[k] = 0;
            m_cnt[k]  = 0;
            adv[k]    = 1'b0;
        end
    endtask

    task automatic check_outputs();
        for (int k = 0; k < 2; k++) begin
            int exp_gray;
            exp_gray = m_cnt[k] ^ (m_cnt[k] / 2);
            check_eq($sformatf("i%0d gray", k), int'(gray_w[k]), exp_gray);
            check_eq($sformatf("i%0d bin", k), int'(bin_w[k]), m_cnt[k]);
            check_eq($sformatf("i%0d valid", k), int'(valid_w[k]), int'(m_mode[k] == 1));
            check_eq($sformatf("i%0d busy", k), int'(busy_w[k]), int'(m_mode[k] == 1));
            check_eq($sformatf("i%0d done", k), int'(done_w[k]), int'(m_mode[k] == 2));
            // Single-bit change is only guaranteed when the wrap spans the full code space.
            if (adv[k] && full_wrap[k]) begin
                check_eq($sformatf("i%0d onebit", k), $countones(gray_w[k] ^ prev_gray[k]), 1);
            end
            prev_gray[k] = gray_w[k];
        end
    endtask

    task automatic model_step();
        if (!rst_n) begin
            model_reset();
            return;
        end
        for (int k = 0; k < 2; k++) begin
            bit term;
            term = 1'b0;
            adv[k] = 1'b0;
            full_wrap[k] = 1'b1;
            case (m_mode[k])
                0: begin
                    if (load) m_cnt[k] = (int'(load_val) > max_c[k]) ? max_c[k] : int'(load_val);
                    if (start) m_mode[k] = 1;
                end
                1: begin
                    if (out_ready) begin
                        if (dir && m_cnt[k] == max_c[k]) begin
                            if (wrap_c[k]) begin
                                m_cnt[k] = 0;
                                adv[k] = 1'b1;
                                full_wrap[k] = (max_c[k] == 2**W - 1);
                            end else term = 1'b1;
                        end else if (!dir && m_cnt[k] == 0) begin
                            if (wrap_c[k]) begin
                                m_cnt[k] = max_c[k];
                                adv[k] = 1'b1;
                                full_wrap[k] = (max_c[k] == 2**W - 1);
                            end else term = 1'b1;
                        end else begin
                            m_cnt[k] = dir ? m_cnt[k] + 1 : m_cnt[k] - 1;
                            adv[k] = 1'b1;
                        end
                    end
                    if (stop) m_mode[k] = 0;
                    else if (term) m_mode[k] = 2;
                end
                default: m_mode[k] = 0;
            endcase
        end
    endtask

    // Inputs are set just after a rising edge; outputs are checked on the falling edge.
    task automatic cycle();
        @(negedge clk);
        check_outputs();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic wait_cnt0(input int v);
        int n;
        n = 0;
        while (m_cnt[0] != v && n < 40) begin
            cycle();
            n++;
        end
        check_eq("wait_cnt0 bound", int'(n < 40), 1);
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        #2;
        model_reset();
        for (int k = 0; k < 2; k++) begin
            check_eq($sformatf("i%0d async gray", k), int'(gray_w[k]), 0);
            check_eq($sformatf("i%0d async valid", k), int'(valid_w[k]), 0);
            check_eq($sformatf("i%0d async done", k), int'(done_w[k]), 0);
        end
    endtask

    initial begin
        model_reset();
        for (int k = 0; k < 2; k++) prev_gray[k] = '0;
        run(3);
        rst_n = 1'b1;
        #1;

        // Full up run to terminal, done pulse, back to idle.
        start = 1'b1; dir = 1'b1; out_ready = 1'b1;
        cycle();
        start = 1'b0;
        run(20);

        // Loaded down run.
        stop = 1'b1; cycle(); stop = 1'b0;
        load = 1'b1; load_val = 4'd5; start = 1'b1; dir = 1'b0;
        cycle();
        load = 1'b0; start = 1'b0;
        run(10);

        // Backpressure at bin 6.
        stop = 1'b1; cycle(); stop = 1'b0;
        load = 1'b1; load_val = 4'd0; start = 1'b1; dir = 1'b1;
        cycle();
        load = 1'b0; start = 1'b0;
        wait_cnt0(6);
        out_ready = 1'b0; run(3);
        out_ready = 1'b1; run(3);

        // Stop together with accept, then resume; clamped load.
        stop = 1'b1; cycle(); stop = 1'b0;
        load = 1'b1; load_val = 4'd0; start = 1'b1; cycle();
        load = 1'b0; start = 1'b0;
        wait_cnt0(3);
        stop = 1'b1; cycle(); stop = 1'b0;
        run(2);
        start = 1'b1; cycle(); start = 1'b0;
        run(2);
        stop = 1'b1; cycle(); stop = 1'b0;
        load = 1'b1; load_val = 4'd12; cycle(); load = 1'b0;
        run(2);

        // Reset mid-run at bin 7.
        load = 1'b1; load_val = 4'd0; start = 1'b1; cycle();
        load = 1'b0; start = 1'b0;
        wait_cnt0(7);
        apply_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        run(2);

        // Randomised control traffic.
        for (int i = 0; i < 600; i++) begin
            rst_n     = 1'b1;
            start     = ($urandom_range(0, 5) == 0);
            stop      = ($urandom_range(0, 15) == 0);
            load      = ($urandom_range(0, 6) == 0);
            load_val  = W'($urandom_range(0, 15));
            dir       = ($urandom_range(0, 7) != 0) ? dir : ~dir;
            out_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 99) == 0) apply_reset();
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
